// File: rtl/tiny_dnn_pkg.sv
// rtl/tiny_dnn_pkg.sv - shared tiny_dnn widths and the round/saturate helper
package tiny_dnn_pkg;

    localparam int DEF_AW   = 32;
    localparam int DEF_DW   = 16;
    localparam int DEF_FRAC = 8;

    // Round half up by dropping DEF_FRAC bits, then clamp to the signed DEF_DW range.
    function automatic logic [DEF_DW-1:0] round_sat(input logic signed [DEF_AW:0] s);
        logic signed [DEF_AW+1:0] t;
        logic signed [DEF_AW+1:0] r;
        logic signed [DEF_AW+1:0] hi;
        logic signed [DEF_AW+1:0] lo;
        hi = (DEF_AW+2)'((64'd1 << (DEF_DW-1)) - 64'd1);
        lo = ~hi;
        t  = (DEF_AW+2)'(s) + (DEF_AW+2)'(64'd1 << (DEF_FRAC-1));
        r  = t >>> DEF_FRAC;
        if (r > hi)
            return hi[DEF_DW-1:0];
        else if (r < lo)
            return lo[DEF_DW-1:0];
        else
            return r[DEF_DW-1:0];
    endfunction

endpackage

// File: rtl/tiny_dnn_out_ctl_if.sv
// rtl/tiny_dnn_out_ctl_if.sv - output buffer write port
interface tiny_dnn_out_ctl_if
    import tiny_dnn_pkg::*;
#(
    parameter int DW = DEF_DW
);
    logic          ob_we;
    logic [11:0]   oa;
    logic [DW-1:0] ob_wd;
    logic          ob_ready;

    modport master (output ob_we, output oa, output ob_wd, input ob_ready);
    modport slave  (input ob_we, input oa, input ob_wd, output ob_ready);
endinterface

// File: rtl/tiny_dnn_out_cnt.sv
// rtl/tiny_dnn_out_cnt.sv - ox/oy/dc wrap counter chain for output positions
module tiny_dnn_out_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    input  logic [3:0] dd,
    input  logic [4:0] oh,
    input  logic [4:0] ow,
    output logic [3:0] dc,
    output logic [4:0] oy,
    output logic [4:0] ox,
    output logic [3:0] nxt_dc,
    output logic [4:0] nxt_oy,
    output logic [4:0] nxt_ox,
    output logic       last
);
    logic ox_end;
    logic oy_end;
    logic dc_end;

    always_comb begin
        ox_end = (ox == ow);
        oy_end = (oy == oh);
        dc_end = (dc == dd);
        last   = ox_end & oy_end & dc_end;
        nxt_ox = ox_end ? 5'd0 : ox + 5'd1;
        nxt_oy = oy;
        nxt_dc = dc;
        if (ox_end) begin
            nxt_oy = oy_end ? 5'd0 : oy + 5'd1;
            if (oy_end)
                nxt_dc = dc_end ? 4'd0 : dc + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dc <= '0;
            oy <= '0;
            ox <= '0;
        end else if (clr) begin
            dc <= '0;
            oy <= '0;
            ox <= '0;
        end else if (adv) begin
            dc <= nxt_dc;
            oy <= nxt_oy;
            ox <= nxt_ox;
        end
    end
endmodule

// File: rtl/tiny_dnn_out_ctl.sv
// rtl/tiny_dnn_out_ctl.sv - bias/ReLU/round/saturate and output buffer writer
module tiny_dnn_out_ctl
    import tiny_dnn_pkg::*;
#(
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    parameter int FRAC = DEF_FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_init,
    input  logic                 backprop,
    input  logic                 k_fin,
    input  logic signed [AW-1:0] acc,
    input  logic [3:0]           dd,
    input  logic [4:0]           oh,
    input  logic [4:0]           ow,
    input  logic [9:0]           os,
    output logic [3:0]           ba,
    input  logic signed [DW-1:0] bd,
    output logic                 out_busy,
    output logic                 out_fin,
    tiny_dnn_out_ctl_if.master   ob
);
    logic               hv;
    logic               wv;
    logic               fin_q;
    logic signed [AW:0] h_s;
    logic signed [AW:0] s_sum;
    logic signed [AW:0] s_in;
    logic [11:0]        oa_q;
    logic [DW-1:0]      wd_q;
    logic [11:0]        addr;
    logic               accept;
    logic               move;
    logic               h_load;
    logic [3:0]         dc;
    logic [4:0]         oy;
    logic [4:0]         ox;
    logic [3:0]         nxt_dc;
    logic [4:0]         nxt_oy;
    logic [4:0]         nxt_ox;
    logic [3:0]         p_dc;
    logic [4:0]         p_oy;
    logic [4:0]         p_ox;
    logic               last;

    assign accept = wv & ob.ob_ready;
    assign move   = hv & (~wv | accept);
    assign h_load = k_fin & (~hv | move);

    tiny_dnn_out_cnt u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (s_init),
        .adv    (accept),
        .dd     (dd),
        .oh     (oh),
        .ow     (ow),
        .dc     (dc),
        .oy     (oy),
        .ox     (ox),
        .nxt_dc (nxt_dc),
        .nxt_oy (nxt_oy),
        .nxt_ox (nxt_ox),
        .last   (last)
    );

    always_comb begin
        s_sum = (AW+1)'(acc) + ((AW+1)'(bd) <<< FRAC);
        s_in  = (AW+1)'(acc);
        if (!backprop)
            s_in = s_sum[AW] ? '0 : s_sum;
    end

    // When W drains in the same cycle H moves in, the counters still point at
    // the departing write, so the new entry takes the post-advance position.
    always_comb begin
        p_dc = accept ? nxt_dc : dc;
        p_oy = accept ? nxt_oy : oy;
        p_ox = accept ? nxt_ox : ox;
        addr = 12'(p_dc) * 12'(os) + 12'(p_oy) * (12'(ow) + 12'd1) + 12'(p_ox);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hv    <= 1'b0;
            wv    <= 1'b0;
            fin_q <= 1'b0;
            h_s   <= '0;
            oa_q  <= '0;
            wd_q  <= '0;
        end else if (s_init) begin
            hv    <= 1'b0;
            wv    <= 1'b0;
            fin_q <= 1'b0;
            h_s   <= '0;
            oa_q  <= '0;
            wd_q  <= '0;
        end else begin
            fin_q <= accept & last;
            if (h_load) begin
                hv  <= 1'b1;
                h_s <= s_in;
            end else if (move) begin
                hv  <= 1'b0;
            end
            if (move) begin
                wv   <= 1'b1;
                oa_q <= addr;
                wd_q <= round_sat(h_s);
            end else if (accept) begin
                wv   <= 1'b0;
            end
        end
    end

    assign ba       = dc;
    assign out_busy = hv | wv;
    assign out_fin  = fin_q;
    assign ob.ob_we = wv;
    assign ob.oa    = oa_q;
    assign ob.ob_wd = wd_q;

    kfin_dropped: assert property (@(posedge clk) disable iff (!rst) !(k_fin && !s_init && !h_load));
endmodule

// File: tb/tb_tiny_dnn_out_ctl.sv
// tb/tb_tiny_dnn_out_ctl.sv - scoreboard bench for tiny_dnn_out_ctl
module tb_tiny_dnn_out_ctl;
    logic               clk = 1'b0;
    logic               rst;
    logic               s_init = 1'b0;
    logic               backprop = 1'b0;
    logic               k_fin = 1'b0;
    logic signed [31:0] acc = '0;
    logic [3:0]         dd = '0;
    logic [4:0]         oh = '0;
    logic [4:0]         ow = '0;
    logic [9:0]         os = '0;
    logic [3:0]         ba;
    logic signed [15:0] bd = '0;
    logic               out_busy;
    logic               out_fin;

    tiny_dnn_out_ctl_if #(.DW(16)) ob ();

    tiny_dnn_out_ctl dut (
        .clk      (clk),
        .rst      (rst),
        .s_init   (s_init),
        .backprop (backprop),
        .k_fin    (k_fin),
        .acc      (acc),
        .dd       (dd),
        .oh       (oh),
        .ow       (ow),
        .os       (os),
        .ba       (ba),
        .bd       (bd),
        .out_busy (out_busy),
        .out_fin  (out_fin),
        .ob       (ob)
    );

    always #5 clk = ~clk;

    logic signed [15:0] bias_mem [16];
    always @(posedge clk) bd <= bias_mem[ba];

    typedef struct {
        logic [11:0] oa;
        logic [15:0] wd;
        bit          last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   wr_idx = 0;
    bit   rand_rdy = 1'b0;

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
        if (rand_rdy)
            ob.ob_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic int layer_total();
        return (int'(dd) + 1) * (int'(oh) + 1) * (int'(ow) + 1);
    endfunction

    // Reference: bias scaled by 2^8, ReLU, round half up, clamp to 16 bits.
    function automatic logic [15:0] ref_wd(longint a, longint b, bit bp);
        longint s;
        longint r;
        s = a;
        if (!bp) begin
            s = s + b * 256;
            if (s < 0)
                s = 0;
        end
        r = (s + 128) >>> 8;
        if (r > 32767)
            r = 32767;
        if (r < -32768)
            r = -32768;
        return r[15:0];
    endfunction

    function automatic int chan_of(int n);
        return n / ((int'(ow) + 1) * (int'(oh) + 1));
    endfunction

    function automatic void push_exp(logic signed [31:0] a);
        exp_t e;
        int   xs;
        int   ys;
        int   d;
        xs     = int'(ow) + 1;
        ys     = int'(oh) + 1;
        d      = chan_of(wr_idx);
        e.oa   = 12'(d * int'(os) + ((wr_idx / xs) % ys) * xs + (wr_idx % xs));
        e.wd   = ref_wd(longint'(a), longint'(bias_mem[d]), backprop);
        e.last = (wr_idx == layer_total() - 1);
        sb.push_back(e);
        wr_idx = (wr_idx + 1) % layer_total();
    endfunction

    function automatic logic signed [31:0] rand_acc();
        if ($urandom_range(0, 3) == 0)
            return $signed($urandom());
        return $signed(32'($urandom_range(0, 1 << 21))) - 32'sd1048576;
    endfunction

    task automatic wait_idle();
        int b;
        b = 0;
        while (out_busy && b < 500) begin
            tick();
            b++;
        end
        if (b >= 500)
            check("idle_timeout", 1, 0);
    endtask

    task automatic layer(input logic [3:0] d, input logic [4:0] h, input logic [4:0] w,
                         input logic [9:0] s, input bit bp);
        wait_idle();
        tick();
        tick();
        dd       = d;
        oh       = h;
        ow       = w;
        os       = s;
        backprop = bp;
        s_init   = 1'b1;
        tick();
        s_init   = 1'b0;
        wr_idx   = 0;
        check("layer_sb_empty", longint'(sb.size()), 0);
        sb.delete();
    endtask

    // Leaves one idle cycle after out_busy falls so bd reflects the new ba.
    task automatic issue(input logic signed [31:0] a);
        wait_idle();
        tick();
        check("ba", longint'(ba), longint'(chan_of(wr_idx)));
        k_fin = 1'b1;
        acc   = a;
        push_exp(a);
        tick();
        k_fin = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        bit   fin_exp;
        fin_exp = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (fin_exp || out_fin)
                check("out_fin", longint'(out_fin), longint'(fin_exp));
            fin_exp = 1'b0;
            if (ob.ob_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = sb[0];
                    check("oa", longint'(ob.oa), longint'(e.oa));
                    check("ob_wd", longint'(ob.ob_wd), longint'(e.wd));
                    if (ob.ob_ready) begin
                        void'(sb.pop_front());
                        fin_exp = e.last;
                    end
                end
            end
        end
    end

    initial begin : main
        for (int i = 0; i < 16; i++)
            bias_mem[i] = '0;
        ob.ob_ready = 1'b1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        repeat (3) tick();
        check("rst_out_busy", longint'(out_busy), 0);
        check("rst_ob_we", longint'(ob.ob_we), 0);
        check("rst_out_fin", longint'(out_fin), 0);
        check("rst_oa", longint'(ob.oa), 0);
        check("rst_ob_wd", longint'(ob.ob_wd), 0);
        check("rst_ba", longint'(ba), 0);
        rst = 1'b1;
        tick();

        // basic forward write with bias and ReLU, plus latency
        bias_mem[0] = 16'sh0010;
        layer(4'd0, 5'd0, 5'd1, 10'd2, 1'b0);
        issue(32'sh00001000);
        check("lat_busy_t1", longint'(out_busy), 1);
        check("lat_we_t1", longint'(ob.ob_we), 0);
        tick();
        check("lat_busy_t2", longint'(out_busy), 1);
        check("lat_we_t2", longint'(ob.ob_we), 1);
        tick();
        check("lat_busy_t3", longint'(out_busy), 0);
        issue(-32'sh00004000);

        // backprop saturation
        layer(4'd0, 5'd0, 5'd0, 10'd1, 1'b1);
        issue(-32'sh00900000);

        // rounding boundary
        bias_mem[0] = '0;
        layer(4'd0, 5'd0, 5'd1, 10'd2, 1'b0);
        issue(32'sh00000180);
        issue(32'sh0000017F);

        // five-cycle stall after ob_we rises
        layer(4'd0, 5'd0, 5'd0, 10'd1, 1'b0);
        ob.ob_ready = 1'b0;
        issue(32'sh00001234);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_busy", longint'(out_busy), 1);
            check("stall_we", longint'(ob.ob_we), 1);
            tick();
        end
        ob.ob_ready = 1'b1;
        check("stall_busy_last", longint'(out_busy), 1);
        tick();
        check("stall_busy_end", longint'(out_busy), 0);

        // addressing across two channels with random backpressure
        bias_mem[0] = 16'sh0020;
        bias_mem[1] = -16'sh0030;
        layer(4'd1, 5'd1, 5'd1, 10'd6, 1'b0);
        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++)
            issue(rand_acc());
        rand_rdy = 1'b0;
        ob.ob_ready = 1'b1;

        // back-to-back k_fin, exercising H moving while W drains
        layer(4'd1, 5'd2, 5'd3, 10'd100, 1'b1);
        wait_idle();
        tick();
        for (int i = 0; i < 24; i++) begin
            k_fin = 1'b1;
            acc   = rand_acc();
            push_exp(acc);
            tick();
        end
        k_fin = 1'b0;

        // s_init while a write is pending
        layer(4'd0, 5'd1, 5'd1, 10'd2, 1'b1);
        issue(32'sh00000300);
        wait_idle();
        ob.ob_ready = 1'b0;
        issue(32'sh00000500);
        tick();
        check("clr_we_pre", longint'(ob.ob_we), 1);
        s_init = 1'b1;
        tick();
        s_init = 1'b0;
        check("clr_we", longint'(ob.ob_we), 0);
        check("clr_busy", longint'(out_busy), 0);
        sb.delete();
        wr_idx = 0;
        ob.ob_ready = 1'b1;
        issue(32'sh00000700);

        // asynchronous reset while a write is pending
        wait_idle();
        issue(32'sh00000300);
        wait_idle();
        ob.ob_ready = 1'b0;
        issue(32'sh00000500);
        tick();
        rst = 1'b0;
        #1;
        check("arst_we", longint'(ob.ob_we), 0);
        check("arst_busy", longint'(out_busy), 0);
        tick();
        rst = 1'b1;
        sb.delete();
        wr_idx = 0;
        ob.ob_ready = 1'b1;
        tick();
        issue(32'sh00000700);

        // random layers
        for (int l = 0; l < 6; l++) begin
            logic [3:0] rd;
            rd = 4'($urandom_range(0, 5));
            for (int c = 0; c < 16; c++)
                bias_mem[c] = 16'($urandom());
            layer(rd, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
            rand_rdy = 1'b1;
            for (int n = layer_total(); n > 0; n--)
                issue(rand_acc());
            rand_rdy = 1'b0;
            ob.ob_ready = 1'b1;
        end

        wait_idle();
        repeat (3) tick();
        check("final_sb_empty", longint'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
